// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch -- instruction fetch stage with program counter.
//
// Holds the PC, issues one instruction-memory request at a time, captures the
// returned word and presents it to decode with a valid/ready handshake. When
// decode accepts, pc_ena pulses and the PC loads the (word-aligned) next_pc
// computed externally by mux_pc. A flush from a later stage redirects the PC
// and discards whatever is in flight; a response that is still owed to an
// abandoned request is swallowed in the DROP state.
//
// Ports
//   clk            in   1          system clock, rising edge
//   rst            in   1          asynchronous, active-high reset
//   next_pc        in   CPU_WIDTH  next PC from mux_pc
//   curr_pc        out  CPU_WIDTH  PC register (to mux_pc)
//   pc_ena         out  1          decode accepted an instruction this cycle
//   flush          in   1          redirect request
//   flush_pc       in   CPU_WIDTH  redirect target
//   imem_req_valid out  1          instruction-memory request valid
//   imem_req_ready in   1          memory accepts the request
//   imem_addr      out  CPU_WIDTH  request address
//   imem_rsp_valid in   1          response data valid
//   imem_rsp_data  in   32         instruction word
//   id_valid       out  1          instruction valid to decode
//   id_ready       in   1          decode accepts
//   id_inst        out  32         held instruction
//   id_pc          out  CPU_WIDTH  PC of id_inst
//   inst_cnt       out  32         instructions accepted by decode (wraps)
//
// Parameters
//   CPU_WIDTH      PC/address width (normally from rvseed_defines.v)
//   RESET_PC       PC after reset
//   INST_CNT_INIT  inst_cnt value after reset; 0 in normal use, a non-zero
//                  value lets bring-up exercise the counter wrap quickly
// ---------------------------------------------------------------------------
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module pc_fetch #(
  parameter int                   CPU_WIDTH     = `CPU_WIDTH,
  parameter logic [CPU_WIDTH-1:0] RESET_PC      = 32'h0000_0000,
  parameter logic [31:0]          INST_CNT_INIT = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CPU_WIDTH-1:0] next_pc,
  output logic [CPU_WIDTH-1:0] curr_pc,
  output logic                 pc_ena,
  input  logic                 flush,
  input  logic [CPU_WIDTH-1:0] flush_pc,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [CPU_WIDTH-1:0] imem_addr,
  input  logic                 imem_rsp_valid,
  input  logic [31:0]          imem_rsp_data,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [31:0]          id_inst,
  output logic [CPU_WIDTH-1:0] id_pc,
  output logic [31:0]          inst_cnt
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request outstanding to memory, waiting for ready
    S_WAIT = 2'd1,  // request accepted, waiting for the response
    S_HOLD = 2'd2,  // instruction held for decode
    S_DROP = 2'd3   // a response is owed to an abandoned request
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   capture;     // load id_inst/id_pc this cycle
  logic                   accept;      // decode takes the held instruction
  logic [CPU_WIDTH-1:0]   pc_next;

  // Instructions are 32-bit aligned; the two low PC bits are always forced
  // to zero whatever the source of the new PC.
  function automatic logic [CPU_WIDTH-1:0] word_align(
    input logic [CPU_WIDTH-1:0] addr
  );
    return {addr[CPU_WIDTH-1:2], 2'b00};
  endfunction

  // Next-state and handshake decode. Flush outranks every other event, and
  // its target state depends on whether a response is still owed: if one is,
  // DROP swallows it so it cannot be mistaken for the redirected fetch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    accept     = 1'b0;
    case (state)
      S_REQ: begin
        if (flush) begin
          state_next = imem_req_ready ? S_DROP : S_REQ;
        end else if (imem_req_ready) begin
          state_next = S_WAIT;
        end else begin
          state_next = S_REQ;
        end
      end
      S_WAIT: begin
        if (flush) begin
          // A response arriving with the flush is the one owed; discard it.
          state_next = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          capture    = 1'b1;
          state_next = S_HOLD;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_HOLD: begin
        // Responses here are protocol errors and are ignored.
        if (flush) begin
          state_next = S_REQ;
        end else if (id_ready) begin
          accept     = 1'b1;
          state_next = S_REQ;
        end else begin
          state_next = S_HOLD;
        end
      end
      S_DROP: begin
        if (flush) begin
          state_next = S_DROP;
        end else if (imem_rsp_valid) begin
          state_next = S_REQ;
        end else begin
          state_next = S_DROP;
        end
      end
      default: begin
        state_next = S_REQ;
      end
    endcase
  end

  // PC source selection: flush redirect, then decode acceptance, else hold.
  always_comb begin
    pc_next = curr_pc;
    if (flush) begin
      pc_next = word_align(flush_pc);
    end else if (accept) begin
      pc_next = word_align(next_pc);
    end else begin
      pc_next = curr_pc;
    end
  end

  // Output decode from the state register. The request is masked while
  // reset is held so the memory sees no request until reset releases.
  always_comb begin
    imem_req_valid = 1'b0;
    id_valid       = 1'b0;
    imem_addr      = curr_pc;
    pc_ena         = accept;
    if (state == S_REQ) begin
      imem_req_valid = ~rst;
    end else begin
      imem_req_valid = 1'b0;
    end
    if (state == S_HOLD) begin
      id_valid = 1'b1;
    end else begin
      id_valid = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_next;
    end
  end

  // Program counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curr_pc <= RESET_PC;
    end else begin
      curr_pc <= pc_next;
    end
  end

  // Instruction hold register; written only by a response taken in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_inst <= NOP_INST;
      id_pc   <= RESET_PC;
    end else if (capture) begin
      id_inst <= imem_rsp_data;
      id_pc   <= curr_pc;
    end else begin
      id_inst <= id_inst;
      id_pc   <= id_pc;
    end
  end

  // Accepted-instruction counter; wraps naturally modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_cnt <= INST_CNT_INIT;
    end else if (accept) begin
      inst_cnt <= inst_cnt + 32'd1;
    end else begin
      inst_cnt <= inst_cnt;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch -- directed self-checking bench for pc_fetch.
//
// A transaction-level model tracks what the fetch stage owes (a request to
// issue, a response to capture, a response to discard, an instruction held
// for decode) and predicts every output; a compare process checks the DUT
// against it on each falling clock edge. Directed steps add hand-computed
// literal expectations. A second instance with a counter preset close to
// 2^32 exposes the inst_cnt wrap.
// ---------------------------------------------------------------------------
module tb_pc_fetch;

  localparam logic [31:0] CNT2_INIT = 32'hFFFF_FFFB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        id_ready = 1'b0;
  logic        np_ovr_en = 1'b0;
  logic [31:0] np_ovr = 32'h0;
  logic [31:0] next_pc;

  logic [31:0] curr_pc, imem_addr, id_inst, id_pc, inst_cnt;
  logic        pc_ena, imem_req_valid, id_valid;
  logic [31:0] curr_pc2, imem_addr2, id_inst2, id_pc2, inst_cnt2;
  logic        pc_ena2, imem_req_valid2, id_valid2;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0] m_pc, m_inst, m_ipc, m_cnt;
  logic        m_pending, m_drop, m_have;
  logic        m_issuing;
  assign m_issuing = !(m_pending || m_drop || m_have);

  // mux_pc stand-in: sequential PC unless a directed override is active.
  assign next_pc = np_ovr_en ? np_ovr : (m_pc + 32'd4);

  always #5 clk = ~clk;

  pc_fetch #(.CPU_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .curr_pc(curr_pc),
    .pc_ena(pc_ena), .flush(flush), .flush_pc(flush_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .inst_cnt(inst_cnt)
  );

  pc_fetch #(.CPU_WIDTH(32), .RESET_PC(32'h0000_0000),
             .INST_CNT_INIT(CNT2_INIT)) dut2 (
    .clk(clk), .rst(rst), .next_pc(next_pc), .curr_pc(curr_pc2),
    .pc_ena(pc_ena2), .flush(flush), .flush_pc(flush_pc),
    .imem_req_valid(imem_req_valid2), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr2), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .id_valid(id_valid2), .id_ready(id_ready),
    .id_inst(id_inst2), .id_pc(id_pc2), .inst_cnt(inst_cnt2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what is owed, updated on each clock from the inputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'h0; m_inst <= 32'h0000_0013; m_ipc <= 32'h0; m_cnt <= 32'h0;
      m_pending <= 1'b0; m_drop <= 1'b0; m_have <= 1'b0;
    end else if (flush) begin
      m_pc      <= flush_pc & 32'hFFFF_FFFC;
      m_drop    <= (m_issuing && imem_req_ready) || (m_pending && !imem_rsp_valid) || m_drop;
      m_pending <= 1'b0;
      m_have    <= 1'b0;
    end else if (m_issuing) begin
      if (imem_req_ready) m_pending <= 1'b1;
    end else if (m_pending) begin
      if (imem_rsp_valid) begin
        m_inst <= imem_rsp_data; m_ipc <= m_pc;
        m_pending <= 1'b0; m_have <= 1'b1;
      end
    end else if (m_have) begin
      if (id_ready) begin
        m_pc <= next_pc & 32'hFFFF_FFFC;
        m_cnt <= m_cnt + 32'd1;
        m_have <= 1'b0;
      end
    end else begin
      if (imem_rsp_valid) m_drop <= 1'b0;
    end
  end

  // Cycle counter and address recorder for the throughput test.
  int          cyc_n = 0;
  logic        rec_en = 1'b0;
  logic [31:0] rec_addr[$];
  int          rec_cyc[$];
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Compare process: every falling edge, DUT against model.
  always @(negedge clk) begin
    if (!rst) chk("req_valid", {31'd0, imem_req_valid}, {31'd0, m_issuing});
    chk("imem_addr", imem_addr, m_pc);
    chk("curr_pc", curr_pc, m_pc);
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_have});
    chk("pc_ena", {31'd0, pc_ena}, {31'd0, m_have && id_ready && !flush && !rst});
    chk("id_inst", id_inst, m_inst);
    chk("id_pc", id_pc, m_ipc);
    chk("inst_cnt", inst_cnt, m_cnt);
    chk("inst_cnt2", inst_cnt2, m_cnt + CNT2_INIT);
    if (rec_en && imem_req_valid) begin
      rec_addr.push_back(imem_addr);
      rec_cyc.push_back(cyc_n);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and release
    cyc(2);
    rst = 1'b0;
    #1;
    chk("rst_curr_pc", curr_pc, 32'h0);
    chk("rst_inst_cnt", inst_cnt, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0000_0013);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);

    // Back-to-back fetch at full rate: 0x0, 0x4, 0x8 three cycles apart
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; id_ready = 1'b1;
    imem_rsp_data = 32'h1111_0013;
    rec_en = 1'b1;
    cyc(9);
    rec_en = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; id_ready = 1'b0;
    chk("tput_cnt", inst_cnt, 32'd3);
    chk("tput_nreq", rec_addr.size(), 32'd3);
    if (rec_addr.size() == 3) begin
      chk("tput_a0", rec_addr[0], 32'h0);
      chk("tput_a1", rec_addr[1], 32'h4);
      chk("tput_a2", rec_addr[2], 32'h8);
      chk("tput_gap1", rec_cyc[1] - rec_cyc[0], 32'd3);
      chk("tput_gap2", rec_cyc[2] - rec_cyc[1], 32'd3);
    end

    // Decode stalls 5 cycles in HOLD
    imem_req_ready = 1'b1; cyc(1);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0040_0513; cyc(1);
    imem_rsp_valid = 1'b0;
    cyc(5);
    chk("stall_id_valid", {31'd0, id_valid}, 32'd1);
    chk("stall_id_inst", id_inst, 32'h0040_0513);
    chk("stall_id_pc", id_pc, 32'h0000_000C);
    chk("stall_curr_pc", curr_pc, 32'h0000_000C);
    chk("stall_pc_ena", {31'd0, pc_ena}, 32'd0);
    id_ready = 1'b1; #1;
    chk("accept_pc_ena", {31'd0, pc_ena}, 32'd1);
    cyc(1);
    id_ready = 1'b0;
    chk("accept_curr_pc", curr_pc, 32'h0000_0010);
    chk("accept_cnt", inst_cnt, 32'd4);

    // Flush in WAIT, response two cycles later is dropped
    imem_req_ready = 1'b1; cyc(1);
    imem_req_ready = 1'b0; flush = 1'b1; flush_pc = 32'h0000_0100; cyc(1);
    flush = 1'b0;
    chk("drop_curr_pc", curr_pc, 32'h0000_0100);
    chk("drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
    cyc(1);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; cyc(1);
    imem_rsp_valid = 1'b0;
    chk("drop_req_after", {31'd0, imem_req_valid}, 32'd1);
    chk("drop_addr", imem_addr, 32'h0000_0100);
    chk("drop_id_inst", id_inst, 32'h0040_0513);
    chk("drop_id_valid", {31'd0, id_valid}, 32'd0);

    // Flush together with id_ready in HOLD (unaligned target)
    imem_req_ready = 1'b1; cyc(1);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A0_0093; cyc(1);
    imem_rsp_valid = 1'b0; id_ready = 1'b1; flush = 1'b1; flush_pc = 32'h0000_0043; #1;
    chk("fh_pc_ena", {31'd0, pc_ena}, 32'd0);
    cyc(1);
    flush = 1'b0; id_ready = 1'b0;
    chk("fh_curr_pc", curr_pc, 32'h0000_0040);
    chk("fh_cnt", inst_cnt, 32'd4);
    chk("fh_cnt2", inst_cnt2, 32'hFFFF_FFFF);
    chk("fh_req_valid", {31'd0, imem_req_valid}, 32'd1);

    // Unaligned next_pc, and counter wrap on the preset instance
    imem_req_ready = 1'b1; cyc(1);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; cyc(1);
    imem_rsp_valid = 1'b0; np_ovr_en = 1'b1; np_ovr = 32'h0000_0203; id_ready = 1'b1; cyc(1);
    id_ready = 1'b0; np_ovr_en = 1'b0;
    chk("np_curr_pc", curr_pc, 32'h0000_0200);
    chk("np_id_pc", id_pc, 32'h0000_0040);
    chk("np_cnt", inst_cnt, 32'd5);
    chk("wrap_cnt2", inst_cnt2, 32'h0);

    // Flush in REQ without / with ready, DROP held by flush, WAIT flush+rsp
    flush = 1'b1; flush_pc = 32'h0000_0080; cyc(1);
    chk("fr_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("fr_addr", imem_addr, 32'h0000_0080);
    flush_pc = 32'h0000_0084; imem_req_ready = 1'b1; cyc(1);
    chk("frr_req_valid", {31'd0, imem_req_valid}, 32'd0);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; cyc(1);
    chk("fd_req_valid", {31'd0, imem_req_valid}, 32'd0);
    flush = 1'b0; cyc(1);
    imem_rsp_valid = 1'b0;
    chk("fd_addr", imem_addr, 32'h0000_0084);
    chk("fd_req_after", {31'd0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1; cyc(1);
    imem_req_ready = 1'b0; flush = 1'b1; flush_pc = 32'h0000_0090; imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0BAD_0BAD; cyc(1);
    flush = 1'b0; imem_rsp_valid = 1'b0;
    chk("fw_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("fw_addr", imem_addr, 32'h0000_0090);
    chk("fw_id_inst", id_inst, 32'h00A0_0093);

    // Reset asserted mid-WAIT takes effect before the next edge
    imem_req_ready = 1'b1; cyc(1);
    imem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_curr_pc", curr_pc, 32'h0);
    chk("ar_cnt", inst_cnt, 32'h0);
    chk("ar_cnt2", inst_cnt2, CNT2_INIT);
    chk("ar_id_inst", id_inst, 32'h0000_0013);
    chk("ar_id_pc", id_pc, 32'h0);
    chk("ar_id_valid", {31'd0, id_valid}, 32'd0);
    chk("ar_pc_ena", {31'd0, pc_ena}, 32'd0);
    cyc(1);
    rst = 1'b0; #1;
    chk("ar_req_valid", {31'd0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1; cyc(1);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_1111; cyc(1);
    imem_rsp_valid = 1'b0;
    chk("ar_no_drop", {31'd0, id_valid}, 32'd1);
    chk("ar_id_pc2", id_pc, 32'h0);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL have parameter CPU_WIDTH, default `CPU_WIDTH (32) from rvseed_defines.v, giving the PC/address width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value after reset.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 next_pc  in  CPU_WIDTH  next PC value computed by mux_pc.
REQ-007 curr_pc  out  CPU_WIDTH  PC register; drives mux_pc curr_pc.
REQ-008 pc_ena  out  1  one-cycle pulse when decode accepts an instruction; drives mux_pc ena.
REQ-009 flush  in  1  redirect request from a later stage.
REQ-010 flush_pc  in  CPU_WIDTH  redirect target.
REQ-011 imem_req_valid  out  1  instruction-memory request valid.
REQ-012 imem_req_ready  in  1  memory accepts the request.
REQ-013 imem_addr  out  CPU_WIDTH  request address.
REQ-014 imem_rsp_valid  in  1  read data valid; one response per accepted request, any latency of 1 cycle or more.
REQ-015 imem_rsp_data  in  32  instruction word.
REQ-016 id_valid  out  1  instruction valid to decode.
REQ-017 id_ready  in  1  decode accepts the instruction.
REQ-018 id_inst  out  32  held instruction.
REQ-019 id_pc  out  CPU_WIDTH  PC of id_inst.
REQ-020 inst_cnt  out  32  count of instructions accepted by decode.

Function
REQ-021 The FSM SHALL have four states, REQ, WAIT, HOLD and DROP, and SHALL be in REQ after reset.
REQ-022 In REQ: imem_req_valid=1 and imem_addr=curr_pc; when imem_req_ready=1 the FSM SHALL move to WAIT; otherwise it SHALL stay in REQ with the address held stable.
REQ-023 In WAIT: when imem_rsp_valid=1 the block SHALL capture imem_rsp_data into id_inst and curr_pc into id_pc, then move to HOLD.
REQ-024 In HOLD: id_valid=1 with id_inst and id_pc stable; when id_ready=1 the block SHALL assert pc_ena for that cycle, load curr_pc with {next_pc[CPU_WIDTH-1:2],2'b00}, increment inst_cnt, and move to REQ.
REQ-025 Minimum throughput SHALL be one instruction per 3 cycles (REQ, WAIT, HOLD) when ready/valid signals are asserted immediately.
REQ-026 imem_req_valid SHALL be asserted only in REQ, id_valid only in HOLD, and pc_ena only on the HOLD→REQ transition.
REQ-027 On flush=1 the block SHALL load curr_pc with {flush_pc[CPU_WIDTH-1:2],2'b00}, suppress pc_ena and the inst_cnt increment that cycle, and take flush priority over id_ready.
REQ-028 Flush next-state SHALL be: from REQ with imem_req_ready=0, REQ; from REQ with imem_req_ready=1, DROP; from WAIT with imem_rsp_valid=0, DROP; from WAIT with imem_rsp_valid=1, REQ (response discarded); from HOLD, REQ (instruction discarded); from DROP, DROP.
REQ-029 In DROP the block SHALL discard the next response (imem_rsp_valid=1 moves it to REQ) and SHALL NOT write id_inst.
REQ-030 imem_rsp_valid arriving in REQ or HOLD is a protocol error and SHALL be ignored.
REQ-031 inst_cnt SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-032 On rst=1 the block SHALL immediately set state=REQ, curr_pc=RESET_PC, id_inst=32'h0000_0013 (NOP), id_pc=RESET_PC and inst_cnt=0, forcing imem_req_valid=1 (after rst deasserts), id_valid=0 and pc_ena=0.
REQ-033 Reset asserted with a request outstanding SHALL NOT enter DROP; the memory side is reset together with this block.

Verification
REQ-034 Reset release with RESET_PC=0 and ready/rsp asserted immediately, next_pc=curr_pc+4 -> imem_addr sequence 0x0, 0x4, 0x8 at 3-cycle spacing, and inst_cnt=3 after the third id_ready.
REQ-035 id_ready=0 for 5 cycles in HOLD -> id_valid, id_inst and id_pc stable throughout, pc_ena=0, curr_pc unchanged.
REQ-036 flush (flush_pc=0x100) in WAIT with the response arriving 2 cycles later -> state DROP, response discarded, next imem_addr=0x100, id_valid never asserted for the old PC.
REQ-037 flush together with id_ready in HOLD -> pc_ena=0, curr_pc=flush_pc, inst_cnt unchanged.
REQ-038 next_pc=0x203 -> curr_pc=0x200; inst_cnt preset near 0xFFFF_FFFF -> wraps to 0.
REQ-039 rst asserted mid-WAIT -> all outputs at reset values in the same cycle, before the next clock edge.
